// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

  localparam int DEF_NUM_LINES  = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_ADDR_W     = 32;

  localparam int OFF_W     = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W     = $clog2(DEF_NUM_LINES);
  localparam int TAG_W     = DEF_ADDR_W - IDX_W - OFF_W - 2;
  localparam int LINE_BITS = 32 * DEF_LINE_WORDS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped valid/tag/data storage: async lookup, one synchronous fill port.
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int IDX_BITS  = IDX_W,
  parameter int TAG_BITS  = TAG_W,
  parameter int LINE_W    = LINE_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [LINE_W-1:0]   rd_line,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [LINE_W-1:0]   wr_line
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_BITS-1:0]  tags  [NUM_LINES];
  logic [LINE_W-1:0]    lines [NUM_LINES];

  always_ff @(posedge clk) begin
    if (reset)      valid         <= '0;
    else if (wr_en) valid[wr_idx] <= 1'b1;
  end

  // Tag/data need no reset: valid alone qualifies a lookup.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_line  = lines[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Read-only direct-mapped I-cache controller: same-cycle hits, blocking line fill on miss.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_valid,
  input  logic [ADDR_W-1:0]       if_addr,
  output logic                    if_ready,
  output logic [31:0]             if_inst,
  output logic                    mem_read,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ready,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int OFF_B  = $clog2(LINE_WORDS);
  localparam int IDX_B  = $clog2(NUM_LINES);
  localparam int TAG_B  = ADDR_W - IDX_B - OFF_B - 2;
  localparam int LINE_B = 32 * LINE_WORDS;

  // Byte offset bits [1:0] are dropped: fetches are always word-aligned.
  logic [OFF_B-1:0] off;
  logic [IDX_B-1:0] idx;
  logic [TAG_B-1:0] tag;

  assign off = if_addr[2 +: OFF_B];
  assign idx = if_addr[2+OFF_B +: IDX_B];
  assign tag = if_addr[ADDR_W-1 -: TAG_B];

  state_e state, state_n;
  logic   hit, miss, fill_en;

  logic [IDX_B-1:0]  miss_idx;
  logic [TAG_B-1:0]  miss_tag;
  logic              rd_valid;
  logic [TAG_B-1:0]  rd_tag;
  logic [LINE_B-1:0] rd_line;
  logic [LINE_WORDS-1:0][31:0] rd_words;

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_BITS  (IDX_B),
    .TAG_BITS  (TAG_B),
    .LINE_W    (LINE_B)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill_en),
    .wr_idx   (miss_idx),
    .wr_tag   (miss_tag),
    .wr_line  (mem_rdata)
  );

  assign rd_words = rd_line;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    hit     = 1'b0;
    miss    = 1'b0;
    unique case (state)
      S_IDLE: begin
        hit  = if_valid && rd_valid && (rd_tag == tag);
        miss = if_valid && !hit;
        if (miss) state_n = S_REQ;
      end
      S_REQ:  state_n = S_WAIT;
      S_WAIT: if (mem_ready) state_n = S_FILL;
      S_FILL: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Reset masks every same-cycle effect, including a response landing in WAIT.
  assign if_ready = hit && !reset;
  assign if_inst  = rd_words[off];
  assign mem_read = (state == S_REQ);
  assign fill_en  = (state == S_WAIT) && mem_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      mem_addr   <= '0;
      miss_idx   <= '0;
      miss_tag   <= '0;
    end else begin
      if (hit) hit_count <= hit_count + 32'd1;
      if (miss) begin
        miss_count <= miss_count + 32'd1;
        miss_idx   <= idx;
        miss_tag   <= tag;
        mem_addr   <= {tag, idx, {(OFF_B+2){1'b0}}};
      end
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: expected line requests queued at stimulus, checked at mem_read.
module tb_icache_ctrl;
  import icache_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 if_valid = 1'b0;
  logic [31:0]          if_addr = '0;
  logic                 if_ready;
  logic [31:0]          if_inst;
  logic                 mem_read;
  logic [31:0]          mem_addr;
  logic                 mem_ready = 1'b0;
  logic [LINE_BITS-1:0] mem_rdata = '0;
  logic [31:0]          hit_count;
  logic [31:0]          miss_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  icache_ctrl #(.NUM_LINES(16), .LINE_WORDS(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_valid   (if_valid),
    .if_addr    (if_addr),
    .if_ready   (if_ready),
    .if_inst    (if_inst),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_BITS-1:0] mkline(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; if_valid = 1'b0; mem_ready = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // Holds a fetch until if_ready, playing the memory with latency lat after mem_read.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_inst,
                       input int lat, input logic [LINE_BITS-1:0] line, input int exp_wait);
    int n = 0;
    int rd_at = -1;
    bit done = 0;
    if_valid = 1'b1; if_addr = a;
    while (!done && n < 40) begin
      mem_ready = (rd_at >= 0) && (n == rd_at + lat);
      mem_rdata = line;
      @(negedge clk);
      if (mem_read) begin
        if (exp_q.size() == 0) chk({tag, "_unexpected_mem_read"}, mem_addr, 32'hFFFF_FFFF);
        else chk({tag, "_mem_addr"}, mem_addr, exp_q.pop_front());
        rd_at = n;
      end
      if (if_ready) begin
        chk({tag, "_inst"}, if_inst, exp_inst);
        chk({tag, "_latency"}, n, exp_wait);
        done = 1;
      end
      step();
      n++;
    end
    mem_ready = 1'b0; if_valid = 1'b0;
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_req_drained"}, exp_q.size(), 0);
  endtask

  logic [LINE_BITS-1:0] l0, l100, l40, l20, l80;

  initial begin
    l0   = {32'h002081b3, 32'h00a00113, 32'h00500093, 32'h00000013};
    l100 = mkline(32'h1111_0000);
    l40  = mkline(32'h4040_0000);
    l20  = mkline(32'h2020_0000);
    l80  = mkline(32'h8080_0000);

    // Reset state
    reset = 1'b1; if_valid = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    chk("rst_if_ready", if_ready, 0);
    step(); if_valid = 1'b0; step();
    @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    step();
    reset = 1'b0;

    // Cold miss, L=4 -> ready 7 cycles after miss
    exp_q.push_back(32'h0);
    fetch("cold", 32'h0, 32'h13, 4, l0, 7);
    chk("cold_misses", miss_count, 1);
    chk("cold_hits", hit_count, 1);

    // Spatial hits on consecutive cycles
    fetch("hit4", 32'h4, 32'h00500093, 1, l0, 0);
    fetch("hit8", 32'h8, 32'h00a00113, 1, l0, 0);
    fetch("hitC", 32'hC, 32'h002081b3, 1, l0, 0);
    chk("spatial_hits", hit_count, 4);
    chk("spatial_misses", miss_count, 1);

    // Misaligned byte address reads word 1
    fetch("mis6", 32'h6, 32'h00500093, 1, l0, 0);
    chk("mis6_hits", hit_count, 5);

    // Conflict eviction on index 0
    do_reset();
    exp_q.push_back(32'h000);
    fetch("evA", 32'h000, 32'h13, 2, l0, 5);
    exp_q.push_back(32'h100);
    fetch("evB", 32'h100, 32'h1111_0000, 3, l100, 6);
    exp_q.push_back(32'h000);
    fetch("evC", 32'h000, 32'h13, 1, l0, 4);
    chk("evict_misses", miss_count, 3);
    chk("evict_hits", hit_count, 3);

    // Reset mid-miss, stale response afterwards
    do_reset();
    exp_q.push_back(32'h40);
    if_valid = 1'b1; if_addr = 32'h40;
    @(negedge clk); chk("rmm_miss_ready", if_ready, 0);
    step();
    @(negedge clk);
    chk("rmm_mem_read", mem_read, 1);
    chk("rmm_mem_addr", mem_addr, exp_q.pop_front());
    step();
    reset = 1'b1; if_valid = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rmm_post_rst_read", mem_read, 0);
    chk("rmm_post_rst_misses", miss_count, 0);
    step();
    mem_ready = 1'b1; mem_rdata = l40;
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rmm_stale_read", mem_read, 0);
    chk("rmm_stale_hits", hit_count, 0);
    chk("rmm_stale_misses", miss_count, 0);
    step();
    exp_q.push_back(32'h40);
    fetch("rmm_refetch", 32'h40, 32'h4040_0000, 2, l40, 5);
    chk("rmm_misses", miss_count, 1);

    // Address change during stall
    exp_q.push_back(32'h20);
    if_valid = 1'b1; if_addr = 32'h20;
    @(negedge clk); chk("chg_miss_ready", if_ready, 0);
    step();
    @(negedge clk);
    chk("chg_mem_read", mem_read, 1);
    chk("chg_mem_addr", mem_addr, exp_q.pop_front());
    step();
    if_addr = 32'h80;
    @(negedge clk);
    chk("chg_wait_addr", mem_addr, 32'h20);
    chk("chg_wait_ready", if_ready, 0);
    step();
    mem_ready = 1'b1; mem_rdata = l20;
    @(negedge clk); chk("chg_ready_in_wait", if_ready, 0);
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("chg_fill_ready", if_ready, 0);
    chk("chg_fill_read", mem_read, 0);
    step();
    exp_q.push_back(32'h80);
    fetch("chg_new", 32'h80, 32'h8080_0000, 1, l80, 4);
    fetch("chg_line20", 32'h2C, 32'h2020_0003, 1, l20, 0);
    chk("chg_misses", miss_count, 3);
    chk("chg_hits", hit_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
